bpsk_bit_slicer: RTL
====================

# bpsk_bit_slicer

Receive-side stage that consumes the signed carrier samples produced by the sine generator (the `amp` stream) and recovers the transmitted BPSK bits. Each sample is multiplied by a square-wave reference and the products are accumulated over one carrier period. The sign of the result decides the bit, and its magnitude flags weak decisions. Recovered bits are also packed MSB-first into bytes, which gives the packet checker downstream byte-level output.

## Interface
- `DATA_WIDTH`, 12, width of the signed input sample.
- `WAVELENGTH`, 64, samples per symbol (one carrier period); a power of two, at least 4.
- `ACC_WIDTH`, 19, signed accumulator width; at least DATA_WIDTH + log2(WAVELENGTH) + 1.
- `THRESHOLD`, 0, unsigned; a bit is weak when |acc| <= THRESHOLD.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sample_in`  in  DATA_WIDTH  signed two's-complement carrier sample.
- `sample_valid`  in  1  sample_in is accepted on this edge.
- `sync`  in  1  symbol/packet boundary marker.
- `bit_out`  out  1  recovered bit.
- `bit_weak`  out  1  low-confidence flag for bit_out.
- `bit_valid`  out  1  one-cycle pulse; bit_out and bit_weak are valid.
- `byte_out`  out  8  last 8 recovered bits, first-received bit in [7].
- `byte_valid`  out  1  one-cycle pulse; byte_out is complete.

## Operation
- States:
  - IDLE: all samples are ignored.
  - RUN: samples are correlated.
- Transitions:
  - Reset enters IDLE.
  - `sync`=1 on any edge enters RUN, or restarts it if already in RUN.
- Internal registers:
  - Sample index `cnt`, range 0..WAVELENGTH-1.
  - Accumulator `acc`, signed ACC_WIDTH.
  - Bit index `bcnt`, range 0..7.
  - Shift register `sh`, 8 bits.
- Correlation runs on each accepted sample in RUN:
  - Sign-extend sample_in to ACC_WIDTH before any arithmetic.
  - Product is +sample for cnt < WAVELENGTH/2, otherwise -sample.
  - Negating -2^(DATA_WIDTH-1) is exact after the extension.
- When cnt = WAVELENGTH-1, the symbol closes:
  - Compute the final sum s = acc + product, which includes the current sample.
  - Decision: bit_out = (s < 0), so in-phase is 0 and phase-inverted is 1.
  - Weakness: bit_weak = (|s| <= THRESHOLD).
  - acc and cnt clear to 0.
  - Shift the bit into sh: sh <= {sh[6:0], bit}.
  - bcnt increments modulo 8.
- Otherwise an accepted sample sets acc <= acc + product and cnt <= cnt + 1.
- `sync` with `sample_valid` on the same edge:
  - Discard any partial symbol and clear bcnt.
  - The current sample is processed as index 0: acc <= product(index 0), cnt <= 1.
- `sync` without `sample_valid`:
  - acc, cnt and bcnt clear to 0.
  - No output pulse.
- A partial symbol never produces bit_valid.
- A weak bit is still emitted and shifted in; it is only flagged.
- Byte completion: when the closing bit is bcnt = 7, byte_out <= {sh[6:0], bit} and byte_valid pulses.
- Gaps in sample_valid stall all state. cnt, acc and bcnt hold.

## Timing
- Reset values:
  - State IDLE.
  - acc, cnt, bcnt, sh = 0.
  - bit_out, bit_weak, bit_valid, byte_valid = 0.
  - byte_out = 8'h00.
- Reset asserted mid-symbol or mid-byte aborts immediately and clears everything. No pulse appears while reset is high or on the first edge after release.
- All outputs are registered. bit_valid rises on the clock edge after the edge that accepted the symbol's last sample, for one cycle (latency 1).
- byte_valid coincides with the bit_valid of the 8th bit. byte_out updates on the same edge and holds until the next byte completes.
- bit_out and bit_weak hold their values between pulses.
- Throughput: one sample per clock. With sample_valid held high, bit_valid pulses every WAVELENGTH cycles.
- Accumulator bound: |s| <= WAVELENGTH*2^(DATA_WIDTH-1) = 131072 at the defaults. This fits ACC_WIDTH = 19 with no wrap.

## Test plan
- Polarity:
  - Stimulus: sync, then 32 samples of +100 followed by 32 of -100, continuous valid.
  - Required: one bit_valid 1 cycle after the 64th sample, with bit_out=0, bit_weak=0 (s=+6400).
  - Repeat with the signs swapped: bit_out=1.
- Extremes:
  - Stimulus: first half -2048, second half +2047.
  - Required: s = -131040, bit_out=1, no overflow.
  - Stimulus: all-zero symbol.
  - Required: bit_out=0, bit_weak=1.
  - With THRESHOLD=6400: the ±100 symbol gives bit_weak=1.
- Byte assembly:
  - Stimulus: modulate bits 0,1,0,0,1,0,0,0 then 0,1,1,0,0,1,0,1.
  - Required: byte_valid twice, byte_out = 8'h48, then 8'h65.
- Stalls:
  - Stimulus: the +100/-100 symbol with sample_valid toggling 1,0 on alternate cycles.
  - Required: identical decision, with bit_valid after the 64th accepted sample (cycle ~127).
- Resync and reset:
  - Stimulus: sync at sample 40 of a symbol.
  - Required: no bit for the partial symbol; the next bit comes 64 samples later and starts a new byte (bcnt=0).
  - Stimulus: reset asserted mid-byte.
  - Required: outputs go to their reset values; samples are ignored until the next sync.

Source files
------------

// File: rtl/bpsk_bit_slicer_if.sv
// Sample stream into the BPSK bit slicer and its recovered bit/byte stream out.
// The master drives samples and sync; the slave (the slicer) drives decisions.
interface bpsk_bit_slicer_if #(
    parameter int DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         sync;
    logic                         bit_out;
    logic                         bit_weak;
    logic                         bit_valid;
    logic [7:0]                   byte_out;
    logic                         byte_valid;

    modport master (
        output sample_in, sample_valid, sync,
        input  bit_out, bit_weak, bit_valid, byte_out, byte_valid
    );

    modport slave (
        input  sample_in, sample_valid, sync,
        output bit_out, bit_weak, bit_valid, byte_out, byte_valid
    );
endinterface

// File: rtl/bpsk_bit_slicer.sv
// BPSK demodulator: correlates each carrier period against a square-wave reference,
// slices the sign into a bit, flags weak decisions and packs bits MSB-first into bytes.
module bpsk_bit_slicer #(
    parameter int          DATA_WIDTH = 12,
    parameter int          WAVELENGTH = 64,
    parameter int          ACC_WIDTH  = 19,
    parameter int unsigned THRESHOLD  = 0
) (
    input logic             clock,
    input logic             reset,
    bpsk_bit_slicer_if.slave bus
);
    localparam int CNT_W = $clog2(WAVELENGTH);
    localparam logic [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESHOLD);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [2:0]                   bcnt;
    // Only the 7 most recent bits are ever needed: the closing bit completes the byte.
    logic [6:0]                   sh;

    logic signed [ACC_WIDTH-1:0]  ext;
    logic signed [ACC_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  abs_sum;
    logic                         dec_bit;
    logic                         dec_weak;

    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    always_comb begin
        ext      = {{(ACC_WIDTH-DATA_WIDTH){bus.sample_in[DATA_WIDTH-1]}}, bus.sample_in};
        // The reference is +1 for the first half-period and -1 for the second.
        product  = cnt[CNT_W-1] ? -ext : ext;
        sum      = acc + product;
        abs_sum  = sum[ACC_WIDTH-1] ? -sum : sum;
        dec_bit  = sum[ACC_WIDTH-1];
        dec_weak = $unsigned(abs_sum) <= THR;
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            bcnt           <= '0;
            sh             <= '0;
            bus.bit_out    <= 1'b0;
            bus.bit_weak   <= 1'b0;
            bus.bit_valid  <= 1'b0;
            bus.byte_out   <= 8'h00;
            bus.byte_valid <= 1'b0;
        end else begin
            bus.bit_valid  <= 1'b0;
            bus.byte_valid <= 1'b0;
            if (bus.sync) begin
                // A resync drops any partial symbol and starts a fresh byte.
                state <= RUN;
                bcnt  <= '0;
                if (bus.sample_valid) begin
                    acc <= ext;
                    cnt <= CNT_W'(1);
                end else begin
                    acc <= '0;
                    cnt <= '0;
                end
            end else if (state == RUN && bus.sample_valid) begin
                if (&cnt) begin
                    acc           <= '0;
                    cnt           <= '0;
                    bus.bit_out   <= dec_bit;
                    bus.bit_weak  <= dec_weak;
                    bus.bit_valid <= 1'b1;
                    sh            <= {sh[5:0], dec_bit};
                    bcnt          <= bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        bus.byte_out   <= {sh, dec_bit};
                        bus.byte_valid <= 1'b1;
                    end
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule
